// File: rtl/lzrw1_pkg.sv
// Shared LZRW1 types and constants for the matcher and the group packer.
// Holds the item bundle, the packer state encoding and default field widths.
package lzrw1_pkg;

  localparam int GROUP_SIZE = 16;
  localparam int LEN_W      = 4;
  localparam int OFF_W      = 12;

  typedef struct packed {
    logic             is_copy;
    logic [7:0]       literal;
    logic [LEN_W-1:0] length;
    logic [OFF_W-1:0] offset;
  } item_t;

  typedef enum logic [1:0] {
    COLLECT,
    EMIT_CTRL,
    EMIT_DATA
  } state_t;

endpackage

// File: rtl/lzrw1_item_encoder.sv
// Combinational LZRW1 item encoder: item_t -> one or two data bytes + ctrl bit.
// Ports: item in; nbytes (1|2), byte0, byte1, ctrl_bit out.
module lzrw1_item_encoder
  import lzrw1_pkg::*;
(
  input  item_t      item,
  output logic [1:0] nbytes,
  output logic [7:0] byte0,
  output logic [7:0] byte1,
  output logic       ctrl_bit
);

  always_comb begin
    ctrl_bit = item.is_copy;
    nbytes   = item.is_copy ? 2'd2 : 2'd1;
    byte1    = item.offset[7:0];
    if (item.is_copy) begin
      byte0 = {item.length, item.offset[OFF_W-1:8]};
    end else begin
      byte0 = item.literal;
    end
  end

endmodule

// File: rtl/lzrw1_group_packer.sv
// LZRW1 group packer: buffers up to GROUP_SIZE items, then streams ctrl bytes
// followed by item bytes. Ports: item valid/ready in, byte valid/ready out,
// group_done pulse and wrapping bytes_out/groups_out counters.
module lzrw1_group_packer
  import lzrw1_pkg::*;
#(
  parameter int GROUP_SIZE = 16,
  parameter int LEN_W      = 4,
  parameter int OFF_W      = 12,
  parameter int CNT_W      = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             item_valid,
  output logic             item_ready,
  input  logic             item_is_copy,
  input  logic [7:0]       item_literal,
  input  logic [LEN_W-1:0] item_length,
  input  logic [OFF_W-1:0] item_offset,
  input  logic             item_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_byte,
  output logic             out_last,
  output logic             group_done,
  output logic [CNT_W-1:0] bytes_out,
  output logic [CNT_W-1:0] groups_out
);

  localparam int NCB  = GROUP_SIZE / 8;
  localparam int NBUF = 2 * GROUP_SIZE;
  localparam int PW   = $clog2(NBUF + 1);
  localparam int CW   = $clog2(GROUP_SIZE + 1);

  if (LEN_W + OFF_W != 16) begin : g_bad_fields
    $error("lzrw1_group_packer: LEN_W + OFF_W must equal 16");
  end
  if (LEN_W != lzrw1_pkg::LEN_W) begin : g_bad_len
    $error("lzrw1_group_packer: LEN_W must match lzrw1_pkg");
  end
  if ((GROUP_SIZE % 8) != 0 || GROUP_SIZE < 8 || GROUP_SIZE > 32) begin : g_bad_gs
    $error("lzrw1_group_packer: GROUP_SIZE must be 8, 16, 24 or 32");
  end

  state_t                state_q, state_d;
  logic [GROUP_SIZE-1:0] ctrl_q, ctrl_d;
  logic [7:0]            buf_q [NBUF];
  logic [7:0]            buf_d [NBUF];
  logic [PW-1:0]         data_ptr_q, data_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         item_cnt_q, item_cnt_d;
  logic [1:0]            cidx_q, cidx_d;
  logic                  last_flag_q, last_flag_d;
  logic                  group_done_q, group_done_d;
  logic [CNT_W-1:0]      bytes_q, bytes_d;
  logic [CNT_W-1:0]      groups_q, groups_d;

  item_t      item;
  logic [1:0] enc_n;
  logic [7:0] enc_b0;
  logic [7:0] enc_b1;
  logic       enc_ctrl;
  logic [7:0] ctrl_byte;
  logic [7:0] data_byte;
  logic       hs;
  logic       data_final;
  logic [CW-1:0] cnt_next;

  assign item = '{
    is_copy: item_is_copy,
    literal: item_literal,
    length:  item_length,
    offset:  item_offset
  };

  lzrw1_item_encoder u_enc (
    .item     (item),
    .nbytes   (enc_n),
    .byte0    (enc_b0),
    .byte1    (enc_b1),
    .ctrl_bit (enc_ctrl)
  );

  assign item_ready = (state_q == COLLECT);
  assign out_valid  = (state_q != COLLECT);
  assign hs         = out_valid && out_ready;
  assign data_final = (rd_ptr_q + PW'(1)) == data_ptr_q;
  assign cnt_next   = item_cnt_q + CW'(1);

  assign group_done = group_done_q;
  assign bytes_out  = bytes_q;
  assign groups_out = groups_q;

  always_comb begin
    ctrl_byte = 8'h00;
    for (int i = 0; i < NCB; i++) begin
      if (2'(i) == cidx_q) ctrl_byte = ctrl_q[8*i +: 8];
    end
    data_byte = 8'h00;
    for (int i = 0; i < NBUF; i++) begin
      if (PW'(i) == rd_ptr_q) data_byte = buf_q[i];
    end
  end

  always_comb begin
    state_d      = state_q;
    ctrl_d       = ctrl_q;
    buf_d        = buf_q;
    data_ptr_d   = data_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    item_cnt_d   = item_cnt_q;
    cidx_d       = cidx_q;
    last_flag_d  = last_flag_q;
    group_done_d = 1'b0;
    groups_d     = groups_q;
    bytes_d      = bytes_q + CNT_W'(hs);
    out_byte     = 8'h00;
    out_last     = 1'b0;

    case (state_q)
      COLLECT: begin
        if (item_valid) begin
          for (int i = 0; i < NBUF; i++) begin
            if (PW'(i) == data_ptr_q) buf_d[i] = enc_b0;
            if (enc_n == 2'd2 && PW'(i) == data_ptr_q + PW'(1)) begin
              buf_d[i] = enc_b1;
            end
          end
          for (int i = 0; i < GROUP_SIZE; i++) begin
            if (CW'(i) == item_cnt_q) ctrl_d[i] = enc_ctrl;
          end
          data_ptr_d = data_ptr_q + PW'(enc_n);
          item_cnt_d = cnt_next;
          if (cnt_next == CW'(GROUP_SIZE) || item_last) begin
            state_d     = EMIT_CTRL;
            last_flag_d = item_last;
            cidx_d      = 2'd0;
          end
        end
      end
      EMIT_CTRL: begin
        out_byte = ctrl_byte;
        if (hs) begin
          if (cidx_q == 2'(NCB - 1)) begin
            state_d  = EMIT_DATA;
            rd_ptr_d = '0;
          end else begin
            cidx_d = cidx_q + 2'd1;
          end
        end
      end
      EMIT_DATA: begin
        out_byte = data_byte;
        out_last = last_flag_q && data_final;
        if (hs) begin
          rd_ptr_d = rd_ptr_q + PW'(1);
          if (data_final) begin
            state_d      = COLLECT;
            group_done_d = 1'b1;
            groups_d     = groups_q + CNT_W'(1);
            ctrl_d       = '0;
            data_ptr_d   = '0;
            item_cnt_d   = '0;
            last_flag_d  = 1'b0;
          end
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= COLLECT;
      ctrl_q       <= '0;
      for (int i = 0; i < NBUF; i++) buf_q[i] <= 8'h00;
      data_ptr_q   <= '0;
      rd_ptr_q     <= '0;
      item_cnt_q   <= '0;
      cidx_q       <= 2'd0;
      last_flag_q  <= 1'b0;
      group_done_q <= 1'b0;
      bytes_q      <= '0;
      groups_q     <= '0;
    end else begin
      state_q      <= state_d;
      ctrl_q       <= ctrl_d;
      buf_q        <= buf_d;
      data_ptr_q   <= data_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      item_cnt_q   <= item_cnt_d;
      cidx_q       <= cidx_d;
      last_flag_q  <= last_flag_d;
      group_done_q <= group_done_d;
      bytes_q      <= bytes_d;
      groups_q     <= groups_d;
    end
  end

endmodule

// File: tb/tb_lzrw1_group_packer.sv
// Self-checking bench for lzrw1_group_packer (GROUP_SIZE 16 and 8 instances).
// Table of items with hand-computed bytes, plus reset/stall sequences.
module tb_lzrw1_group_packer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        item_valid = 1'b0;
  logic        item_is_copy = 1'b0;
  logic [7:0]  item_literal = 8'h00;
  logic [3:0]  item_length = 4'h0;
  logic [11:0] item_offset = 12'h000;
  logic        item_last = 1'b0;
  logic        out_ready = 1'b0;
  logic        sel = 1'b0;

  always #5 clock = ~clock;

  logic        rdy_a, ov_a, ol_a, gd_a;
  logic [7:0]  ob_a;
  logic [31:0] bo_a, go_a;
  logic        rdy_b, ov_b, ol_b, gd_b;
  logic [7:0]  ob_b;
  logic [31:0] bo_b, go_b;

  logic        m_item_ready, m_out_valid, m_out_last, m_group_done;
  logic [7:0]  m_out_byte;
  logic [31:0] m_bytes, m_groups;

  lzrw1_group_packer #(.GROUP_SIZE(16)) dut16 (
    .clock(clock), .reset(reset),
    .item_valid(item_valid && !sel), .item_ready(rdy_a),
    .item_is_copy(item_is_copy), .item_literal(item_literal),
    .item_length(item_length), .item_offset(item_offset),
    .item_last(item_last),
    .out_valid(ov_a), .out_ready(out_ready && !sel),
    .out_byte(ob_a), .out_last(ol_a), .group_done(gd_a),
    .bytes_out(bo_a), .groups_out(go_a)
  );

  lzrw1_group_packer #(.GROUP_SIZE(8)) dut8 (
    .clock(clock), .reset(reset),
    .item_valid(item_valid && sel), .item_ready(rdy_b),
    .item_is_copy(item_is_copy), .item_literal(item_literal),
    .item_length(item_length), .item_offset(item_offset),
    .item_last(item_last),
    .out_valid(ov_b), .out_ready(out_ready && sel),
    .out_byte(ob_b), .out_last(ol_b), .group_done(gd_b),
    .bytes_out(bo_b), .groups_out(go_b)
  );

  assign m_item_ready = sel ? rdy_b : rdy_a;
  assign m_out_valid  = sel ? ov_b : ov_a;
  assign m_out_byte   = sel ? ob_b : ob_a;
  assign m_out_last   = sel ? ol_b : ol_a;
  assign m_group_done = sel ? gd_b : gd_a;
  assign m_bytes      = sel ? bo_b : bo_a;
  assign m_groups     = sel ? go_b : go_a;

  typedef struct {
    logic       is_copy;
    logic [7:0] lit;
    logic [3:0] len;
    logic [11:0] off;
    logic       last;
    int         n;
    logic [7:0] b0;
    logic [7:0] b1;
  } vec_t;

  vec_t vecs[53];
  int tests = 0;
  int fails = 0;
  logic [7:0] got_b[$];
  logic       got_l[$];

  function automatic vec_t mk(input logic c, input logic [7:0] lit,
                              input logic [3:0] len, input logic [11:0] off,
                              input logic last, input int n,
                              input logic [7:0] b0, input logic [7:0] b1);
    vec_t v;
    v.is_copy = c; v.lit = lit; v.len = len; v.off = off;
    v.last = last; v.n = n; v.b0 = b0; v.b1 = b1;
    return v;
  endfunction

  task automatic check(input bit ok, input string name,
                       input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send(input vec_t v);
    int w = 0;
    item_valid   = 1'b1;
    item_is_copy = v.is_copy;
    item_literal = v.lit;
    item_length  = v.len;
    item_offset  = v.off;
    item_last    = v.last;
    while (!m_item_ready && w < 100) begin
      @(negedge clock);
      w++;
    end
    check(m_item_ready === 1'b1, "item_ready_wait", 32'(m_item_ready), 1);
    @(negedge clock);
    item_valid = 1'b0;
    item_last  = 1'b0;
  endtask

  task automatic collect(input int n, input bit stall);
    int got = 0;
    int cyc = 0;
    bit held_v = 0;
    logic [7:0] held_b = 8'h00;
    got_b.delete();
    got_l.delete();
    while (got < n && cyc < 2000) begin
      out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (held_v) begin
        check(m_out_valid === 1'b1 && m_out_byte === held_b, "stall_hold",
              32'(m_out_byte), 32'(held_b));
      end
      if (m_out_valid) begin
        check(m_item_ready === 1'b0, "ready_low_emit", 32'(m_item_ready), 0);
        if (out_ready) begin
          got_b.push_back(m_out_byte);
          got_l.push_back(m_out_last);
          got++;
          held_v = 0;
        end else begin
          held_v = 1;
          held_b = m_out_byte;
        end
      end
      @(negedge clock);
      cyc++;
    end
    out_ready = 1'b0;
    check(got == n, "collect_timeout", 32'(got), 32'(n));
  endtask

  task automatic run_group(input int start, input int cnt, input int ncb,
                           input logic [31:0] ctrl, input bit stall,
                           input int exp_groups, input int exp_bytes);
    logic [7:0] eb[$];
    logic       el[$];
    for (int i = 0; i < ncb; i++) begin
      eb.push_back(ctrl[8*i +: 8]);
      el.push_back(1'b0);
    end
    for (int i = start; i < start + cnt; i++) begin
      eb.push_back(vecs[i].b0);
      el.push_back(1'b0);
      if (vecs[i].n == 2) begin
        eb.push_back(vecs[i].b1);
        el.push_back(1'b0);
      end
    end
    if (vecs[start + cnt - 1].last) el[el.size() - 1] = 1'b1;
    for (int i = start; i < start + cnt; i++) send(vecs[i]);
    check(m_out_valid === 1'b1, "latency", 32'(m_out_valid), 1);
    collect(eb.size(), stall);
    check(got_b.size() == eb.size(), "byte_count",
          32'(got_b.size()), 32'(eb.size()));
    for (int i = 0; i < eb.size(); i++) begin
      if (i < got_b.size()) begin
        check(got_b[i] === eb[i] && got_l[i] === el[i],
              $sformatf("byte%0d_from%0d", i, start),
              {23'b0, got_l[i], got_b[i]}, {23'b0, el[i], eb[i]});
      end
    end
    check(m_group_done === 1'b1, "group_done_hi", 32'(m_group_done), 1);
    check(m_out_valid === 1'b0, "idle_valid", 32'(m_out_valid), 0);
    check(m_item_ready === 1'b1, "idle_ready", 32'(m_item_ready), 1);
    check(m_groups === 32'(exp_groups), "groups_out", m_groups, 32'(exp_groups));
    check(m_bytes === 32'(exp_bytes), "bytes_out", m_bytes, 32'(exp_bytes));
    @(negedge clock);
    check(m_group_done === 1'b0, "group_done_pulse", 32'(m_group_done), 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      vecs[i] = mk(0, 8'(8'h41 + i), 0, 0, 0, 1, 8'(8'h41 + i), 0);
    end
    vecs[16] = mk(0, 8'h61, 0, 0,      0, 1, 8'h61, 0);
    vecs[17] = mk(1, 0,     3, 12'h123, 0, 2, 8'h31, 8'h23);
    vecs[18] = mk(0, 8'h62, 0, 0,      1, 1, 8'h62, 0);
    for (int i = 19; i < 35; i++) begin
      vecs[i] = mk(1, 0, 4'hF, 12'hFFF, 0, 2, 8'hFF, 8'hFF);
    end
    vecs[35] = mk(0, 8'h10, 0,    0,       0, 1, 8'h10, 0);
    vecs[36] = mk(1, 0,     4'h1, 12'h0AB, 0, 2, 8'h10, 8'hAB);
    vecs[37] = mk(1, 0,     4'hA, 12'h5CD, 0, 2, 8'hA5, 8'hCD);
    vecs[38] = mk(0, 8'h7E, 0,    0,       0, 1, 8'h7E, 0);
    vecs[39] = mk(0, 8'h7F, 0,    0,       1, 1, 8'h7F, 0);
    vecs[40] = mk(0, 8'h01, 0,    0,       0, 1, 8'h01, 0);
    vecs[41] = mk(1, 0,     4'h2, 12'h345, 0, 2, 8'h23, 8'h45);
    vecs[42] = mk(0, 8'h02, 0,    0,       0, 1, 8'h02, 0);
    vecs[43] = mk(1, 0,     4'h4, 12'h067, 0, 2, 8'h40, 8'h67);
    vecs[44] = mk(0, 8'h03, 0,    0,       0, 1, 8'h03, 0);
    vecs[45] = mk(1, 0,     4'hF, 12'hF00, 0, 2, 8'hFF, 8'h00);
    vecs[46] = mk(0, 8'h04, 0,    0,       0, 1, 8'h04, 0);
    vecs[47] = mk(1, 0,     4'h1, 12'h001, 0, 2, 8'h10, 8'h01);
    vecs[48] = mk(0, 8'h21, 0,    0,       0, 1, 8'h21, 0);
    vecs[49] = mk(0, 8'h22, 0,    0,       0, 1, 8'h22, 0);
    vecs[50] = mk(0, 8'h23, 0,    0,       0, 1, 8'h23, 0);
    vecs[51] = mk(0, 8'h24, 0,    0,       1, 1, 8'h24, 0);
    vecs[52] = mk(0, 8'h5A, 0,    0,       1, 1, 8'h5A, 0);

    repeat (2) @(negedge clock);
    check(m_item_ready === 1'b1, "rst_item_ready", 32'(m_item_ready), 1);
    check(m_out_valid === 1'b0, "rst_out_valid", 32'(m_out_valid), 0);
    check(m_out_last === 1'b0, "rst_out_last", 32'(m_out_last), 0);
    check(m_group_done === 1'b0, "rst_group_done", 32'(m_group_done), 0);
    check(m_bytes === 32'd0, "rst_bytes", m_bytes, 0);
    check(m_groups === 32'd0, "rst_groups", m_groups, 0);
    reset = 1'b0;
    @(negedge clock);

    run_group(0, 16, 2, 32'h0000, 0, 1, 18);
    run_group(16, 3, 2, 32'h0002, 0, 2, 24);
    do_reset();
    run_group(19, 16, 2, 32'hFFFF, 0, 1, 34);
    run_group(35, 5, 2, 32'h0006, 1, 2, 43);

    for (int i = 48; i < 52; i++) send(vecs[i]);
    for (int k = 0; k < 3; k++) begin
      out_ready = 1'b1;
      @(negedge clock);
    end
    out_ready = 1'b0;
    check(m_out_valid === 1'b1, "pre_reset_valid", 32'(m_out_valid), 1);
    check(m_bytes === 32'd46, "pre_reset_bytes", m_bytes, 46);
    reset = 1'b1;
    #1;
    check(m_out_valid === 1'b0, "reset_drop_valid", 32'(m_out_valid), 0);
    check(m_item_ready === 1'b1, "reset_ready", 32'(m_item_ready), 1);
    check(m_bytes === 32'd0, "reset_bytes", m_bytes, 0);
    check(m_groups === 32'd0, "reset_groups", m_groups, 0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    run_group(52, 1, 2, 32'h0000, 0, 1, 3);

    sel = 1'b1;
    @(negedge clock);
    run_group(40, 8, 1, 32'h00AA, 0, 1, 13);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
